// File: rtl/mod_exp_lr_engine.sv
// Left-to-right binary modular exponentiation: out = m^e mod n.
// Uses a bit-serial interleaved modular multiplier and skips leading zero exponent bits.
module mod_exp_lr_engine #(
  parameter int BUS_WIDTH = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] m,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [BUS_WIDTH-1:0] n,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 error
);

  localparam int IW = $clog2(EXP_WIDTH) + 1;
  localparam int CW = $clog2(BUS_WIDTH) + 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Handshakes: a request is taken on an edge with start && in_ready; a result
  // is handed over on an edge with out_valid && out_ready.
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, SQ, MUL, NEXT, DONE} state_t;
  state_t state;

  logic [BUS_WIDTH-1:0] m_r, n_r, acc, b;
  logic [EXP_WIDTH-1:0] e_r, e_sh;
  logic [BUS_WIDTH:0]   p, p_dbl, p_add, n_ext;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt;
  logic                 e_bit;

  assign e_sh  = e_r >> idx;
  assign e_bit = e_sh[0];
  assign n_ext = {1'b0, n_r};

  // One interleaved step: P = 2P mod n, then P = (P + acc) mod n when the operand bit is set.
  always_comb begin
    p_dbl = {p[BUS_WIDTH-1:0], 1'b0};
    if (p_dbl >= n_ext) p_dbl = p_dbl - n_ext;
    p_add = b[BUS_WIDTH-1] ? (p_dbl + {1'b0, acc}) : p_dbl;
    if (p_add >= n_ext) p_add = p_add - n_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
      error     <= 1'b0;
      m_r       <= '0;
      e_r       <= '0;
      n_r       <= '0;
      acc       <= '0;
      b         <= '0;
      p         <= '0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r      <= m;
            e_r      <= e;
            n_r      <= n;
            in_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (n_r == '0 || m_r >= n_r) begin
            out       <= '0;
            error     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (e_r == '0) begin
            out       <= {{(BUS_WIDTH-1){1'b0}}, (n_r != BUS_WIDTH'(1))};
            error     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= IDX_TOP;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (e_bit) begin
            acc <= m_r;
            if (idx == '0) begin
              out       <= m_r;
              error     <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx - IDX_ONE;
              b     <= m_r;
              p     <= '0;
              cnt   <= '0;
              state <= SQ;
            end
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        SQ, MUL: begin
          b   <= b << 1;
          p   <= p_add;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            acc <= p_add[BUS_WIDTH-1:0];
            p   <= '0;
            cnt <= '0;
            if (state == SQ && e_bit) begin
              b     <= m_r;
              state <= MUL;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (idx == '0) begin
            out       <= acc;
            error     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx - IDX_ONE;
            b     <= acc;
            p     <= '0;
            cnt   <= '0;
            state <= SQ;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_lr_engine.sv
// Bench for mod_exp_lr_engine: a 16/16 instance for directed cases and a 256/256
// instance for wide random jobs, both checked against a plain-arithmetic model.
module tb_mod_exp_lr_engine;

  logic clk, reset;
  int   n_checks, n_errors;
  logic [255:0] exp_q[$];

  // 16-bit instance
  logic        s_start, s_in_ready, s_out_valid, s_out_ready, s_error;
  logic [15:0] s_m, s_e, s_n, s_out;
  // 256-bit instance
  logic         w_start, w_in_ready, w_out_valid, w_out_ready, w_error;
  logic [255:0] w_m, w_e, w_n, w_out;

  mod_exp_lr_engine #(.BUS_WIDTH(16), .EXP_WIDTH(16)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .m(s_m), .e(s_e), .n(s_n),
    .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .error(s_error));

  mod_exp_lr_engine dut_w (
    .clk(clk), .reset(reset), .start(w_start), .m(w_m), .e(w_e), .n(w_n),
    .in_ready(w_in_ready), .out(w_out), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .error(w_error));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel picks which instance the driver tasks talk to
  logic sel;
  wire [255:0] v_out = sel ? w_out : {240'd0, s_out};
  wire v_ov  = sel ? w_out_valid : s_out_valid;
  wire v_ir  = sel ? w_in_ready : s_in_ready;
  wire v_err = sel ? w_error : s_error;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] xp);
    n_checks++;
    if (act !== xp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, xp);
    end
  endtask

  // reference model: right-to-left square-and-multiply on wide integers
  function automatic logic [255:0] ref_exp(input logic [255:0] mm, input logic [255:0] ee,
                                           input logic [255:0] nn);
    logic [511:0] r, bb, nx;
    if (nn == 0 || mm >= nn) return '0;
    nx = {256'd0, nn};
    r  = 512'd1 % nx;
    bb = {256'd0, mm};
    for (int i = 0; i < 256; i++) begin
      if (ee[i]) r = (r * bb) % nx;
      bb = (bb * bb) % nx;
    end
    return r[255:0];
  endfunction

  function automatic int ref_lat(input logic [255:0] ee, input int ew, input int bw, input logic err);
    int k, lat;
    if (err || ee == 0) return 2;
    k = 0;
    for (int i = 0; i < ew; i++) if (ee[i]) k = i;
    lat = 2 + (ew - k);
    for (int i = 0; i < k; i++) lat += bw * (1 + int'(ee[i])) + 1;
    return lat;
  endfunction

  task automatic drive(input logic [255:0] mm, input logic [255:0] ee, input logic [255:0] nn,
                       input logic st);
    if (sel) begin
      w_m = mm; w_e = ee; w_n = nn; w_start = st;
    end else begin
      s_m = mm[15:0]; s_e = ee[15:0]; s_n = nn[15:0]; s_start = st;
    end
  endtask

  task automatic set_ready(input logic r);
    if (sel) w_out_ready = r; else s_out_ready = r;
  endtask

  // launch one job, wait for the result, check against the model; leaves result pending
  task automatic job(input string name, input logic [255:0] mm, input logic [255:0] ee,
                     input logic [255:0] nn, output logic [255:0] got, output int lat);
    logic xe;
    int   xl, bw, limit;
    bw    = sel ? 256 : 16;
    limit = sel ? 20000 : 2000;
    xe    = (nn == 0) || (mm >= nn);
    xl    = ref_lat(ee, bw, bw, xe);
    exp_q.push_back(ref_exp(mm, ee, nn));
    @(negedge clk);
    chk({name, " in_ready"}, {255'd0, v_ir}, 256'd1);
    drive(mm, ee, nn, 1'b1);
    @(posedge clk);
    #1 drive({8{$urandom}}, {8{$urandom}}, {8{$urandom}}, 1'b0);
    lat = 1;
    while (!v_ov && lat < limit) begin
      @(posedge clk);
      #1 lat++;
    end
    got = v_out;
    chk({name, " latency"}, 256'(lat), 256'(xl));
    chk({name, " out"}, got, exp_q.pop_front());
    chk({name, " error"}, {255'd0, v_err}, {255'd0, xe});
  endtask

  task automatic ack(input string name);
    @(negedge clk);
    set_ready(1'b1);
    @(posedge clk);
    #1;
    chk({name, " ack out_valid"}, {255'd0, v_ov}, 256'd0);
    chk({name, " ack in_ready"}, {255'd0, v_ir}, 256'd1);
    set_ready(1'b0);
  endtask

  initial begin
    logic [255:0] got, held, rm, rn, re;
    int lat;
    n_checks = 0; n_errors = 0; sel = 1'b0;
    reset = 1'b1;
    s_start = 0; s_m = 0; s_e = 0; s_n = 0; s_out_ready = 0;
    w_start = 0; w_m = 0; w_e = 0; w_n = 0; w_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", {240'd0, s_out}, 256'd0);
    chk("reset out_valid", {255'd0, s_out_valid}, 256'd0);
    chk("reset in_ready", {255'd0, s_in_ready}, 256'd1);
    chk("reset error", {255'd0, s_error}, 256'd0);
    chk("reset wide in_ready", {255'd0, w_in_ready}, 256'd1);
    reset = 1'b0;

    // directed cases with hand-computed values
    job("4^13 mod 497", 4, 13, 497, got, lat);
    chk("4^13 literal out", got, 256'd445);
    chk("4^13 literal lat", 256'(lat), 256'd98);
    ack("4^13");
    job("7^1 mod 11", 7, 1, 11, got, lat);
    chk("7^1 literal out", got, 256'd7);
    chk("7^1 literal lat", 256'(lat), 256'd18);
    ack("7^1");
    job("3^0 mod 11", 3, 0, 11, got, lat);
    chk("3^0 literal out", got, 256'd1);
    chk("3^0 literal lat", 256'(lat), 256'd2);
    ack("3^0");
    job("0^0 mod 1", 0, 0, 1, got, lat);
    chk("0^0 mod 1 literal out", got, 256'd0);
    ack("0^0");
    job("n=0", 5, 3, 0, got, lat);
    chk("n=0 literal error", {255'd0, s_error}, 256'd1);
    chk("n=0 literal lat", 256'(lat), 256'd2);
    ack("n=0");
    job("m=n", 11, 3, 11, got, lat);
    chk("m=n literal error", {255'd0, s_error}, 256'd1);
    ack("m=n");

    // output held while the consumer stalls; start pulses must not be queued
    job("stall 5^3 mod 13", 5, 3, 13, held, lat);
    chk("stall literal out", held, 256'd8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(2, 7, 97, 1'b1);
      @(posedge clk);
      #1;
      chk("stall out", {240'd0, s_out}, held);
      chk("stall out_valid", {255'd0, s_out_valid}, 256'd1);
      chk("stall in_ready", {255'd0, s_in_ready}, 256'd0);
    end
    drive(0, 0, 0, 1'b0);
    ack("stall");
    repeat (3) begin
      @(posedge clk);
      #1 chk("no queued start", {255'd0, s_out_valid}, 256'd0);
    end
    chk("error frozen after ack", {255'd0, s_error}, 256'd0);
    chk("out frozen after ack", {240'd0, s_out}, held);

    // reset during the square phase of 4^13
    @(negedge clk);
    drive(4, 13, 497, 1'b1);
    @(posedge clk);
    #1 drive(0, 0, 0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset out", {240'd0, s_out}, 256'd0);
    chk("midreset out_valid", {255'd0, s_out_valid}, 256'd0);
    chk("midreset in_ready", {255'd0, s_in_ready}, 256'd1);
    reset = 1'b0;
    job("3^5 mod 7", 3, 5, 7, got, lat);
    chk("3^5 literal out", got, 256'd5);
    ack("3^5");

    // random 16-bit jobs, full exponent range, occasional invalid m
    for (int t = 0; t < 30; t++) begin
      rn = 256'($urandom_range(1, 65535));
      rm = ($urandom_range(0, 9) == 0) ? 256'($urandom_range(0, 65535)) : 256'($urandom) % rn;
      re = 256'($urandom_range(0, 65535));
      job("rand16", rm, re, rn, got, lat);
      ack("rand16");
    end

    // random 256-bit jobs with short exponents to bound run time
    sel = 1'b1;
    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < 8; j++) rn[j*32 +: 32] = $urandom;
      rn[0] = 1'b1;
      for (int j = 0; j < 8; j++) rm[j*32 +: 32] = $urandom;
      rm = rm % rn;
      re = 256'($urandom_range(1, 31));
      job("rand256", rm, re, rn, got, lat);
      ack("rand256");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
